uart_rx_bit_counter: RTL and testbench
======================================

Name: uart_rx_bit_counter

Overview:
- UART receiver that sits directly downstream of the multi-byte UART transmitter (loopback and host-side model of the XADC serial link).
- Oversamples RxD using a 16x-baud enable tick from a baud generator.
- Assembles NBYTES consecutive 8N1 characters into one word and presents it with a single-cycle valid strobe.
- Reports framing errors and drops partial words after an inter-byte timeout.

Parameters:
- NBYTES, 2, number of characters per word; rx_data width is 8*NBYTES.
- OVERSAMPLE, 16, rx_en ticks per bit period; must be even and at least 8.
- TIMEOUT_BITS, 20, idle bit periods allowed between characters of one word before the partial word is discarded.

Ports:
- clk  input  1  system clock (PLL clock domain).
- rst  input  1  synchronous, active-high reset.
- rx_en  input  1  one-clk-wide tick at OVERSAMPLE x baud rate.
- RxD  input  1  asynchronous serial line; idles high.
- rx_data  output  8*NBYTES  last complete word; first received character occupies bits [7:0].
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rx_busy  output  1  high from start-bit detection until word completion, abort or timeout.
- frame_err  output  1  one-clk pulse on a bad stop bit.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0; FSM to IDLE; byte index, tick counter, bit counter and timeout counter all 0.
- A reset asserted mid-frame aborts the frame with no valid or error pulse.
- RxD synchronisation: 2-FF synchroniser, reset value 1. All decisions below use the synchronised signal and advance only on cycles with rx_en=1.
- IDLE:
  - Synchronised RxD = 0 on a tick: go to START with tick counter = 0.
  - If byte index > 0, the timeout counter runs in IDLE; on reaching TIMEOUT_BITS*OVERSAMPLE ticks, clear byte index, deassert rx_busy, emit no pulse.
- START:
  - At tick OVERSAMPLE/2-1 (mid start bit), sample RxD.
  - Sample 1: glitch. Return to IDLE with byte index and partial data kept.
  - Sample 0: go to DATA with tick counter reset.
- DATA:
  - Sample every OVERSAMPLE ticks at mid-bit.
  - Shift in LSB first; after 8 samples go to STOP.
- STOP: sample at mid-bit.
  - Sample 1:
    - Write the character into slot byte index.
    - If byte index = NBYTES-1: load the full word into rx_data, pulse rx_valid for one clk, clear byte index and rx_busy.
    - Otherwise: increment byte index and return to IDLE (rx_busy stays high, timeout counter cleared).
  - Sample 0:
    - Pulse frame_err, discard the whole partial word, clear byte index, go to WAIT_HIGH.
    - WAIT_HIGH returns to IDLE on the first tick with RxD = 1, so a break condition cannot retrigger reception.
- Latency: rx_valid is asserted 1 clk after the mid-stop-bit sample tick of the last character.
- rx_valid and frame_err are never high in the same cycle.
- Back-to-back characters: the next start bit is accepted as soon as STOP completes, even though only half the stop bit has elapsed.
- Counters: tick counter width clog2(OVERSAMPLE); timeout counter width sized for TIMEOUT_BITS*OVERSAMPLE; byte index width clog2(NBYTES), minimum 1.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH).
  - UART_DATA_BITS=8.
  - Default OVERSAMPLE.
  - A clog2 helper used by both TX and RX.
- One sub-module: sync_2ff (reusable 2-flop synchroniser with parameterised reset value).
- Everything else stays in one FSM module.

Test Plan:
- Loopback with uart_tx_bit_counter (NBYTES=2), tx_data=16'hBC0A -> rx_data=16'hBC0A, one rx_valid pulse, frame_err never high, rx_busy low afterwards.
- Three back-to-back words 16'h1234, 16'hABCD, 16'h00FF -> three rx_valid pulses carrying exactly those values in order.
- RxD low pulse of 3 ticks while IDLE -> return to IDLE; no rx_valid, no frame_err; rx_data unchanged.
- Character 8'h55 sent with stop bit forced 0 -> one frame_err pulse; no rx_valid; next correct word 16'h0F0F received intact.
- Send only the first character 8'hAA, then idle for 25 bit periods -> no outputs, rx_busy drops at 20 bit periods; next word 16'h3C5A received correctly with no byte misalignment.
- Assert rst for 1 clk during bit 4 of the second character -> all outputs 0; next full word 16'h7E81 received correctly.

Source files
------------

// File: rtl/uart_rx_bit_counter_pkg.sv
// Shared UART definitions: receiver FSM states, character width,
// default oversampling ratio and a constant-foldable clog2.
package uart_rx_bit_counter_pkg;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_bit_counter_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised output, RESET_VAL while in reset
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_bit_counter.sv
// Oversampling 8N1 UART receiver assembling NBYTES characters per word.
//   clk, rst  : clock and synchronous active-high reset
//   rx_en     : one-clk tick at OVERSAMPLE x baud
//   RxD       : asynchronous serial line, idles high
//   rx_data   : last complete word, first character in bits [7:0]
//   rx_valid  : one-clk pulse when rx_data updates
//   rx_busy   : high from start-bit detection until completion/abort/timeout
//   frame_err : one-clk pulse on a bad stop bit
module uart_rx_bit_counter
  import uart_rx_bit_counter_pkg::*;
#(
  parameter int unsigned NBYTES       = 2,
  parameter int unsigned OVERSAMPLE   = DEFAULT_OVERSAMPLE,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  RxD,
  output logic [8*NBYTES-1:0]   rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err
);

  localparam int unsigned WORD_W   = UART_DATA_BITS * NBYTES;
  localparam int unsigned TICK_W   = clog2(OVERSAMPLE);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned TO_W     = clog2(TO_LIMIT + 1);
  localparam int unsigned IDX_W    = (NBYTES > 1) ? clog2(NBYTES) : 1;
  localparam int unsigned BIT_W    = clog2(UART_DATA_BITS);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  logic rxd_s;

  rx_state_e           state_q, state_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [TO_W-1:0]     to_q,    to_d;
  logic [7:0]          shift_q, shift_d;
  logic [WORD_W-1:0]   word_q,  word_d;
  logic [WORD_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                busy_q,  busy_d;
  logic                ferr_q,  ferr_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (RxD),
    .q  (rxd_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    to_d    = to_q;
    shift_d = shift_q;
    word_d  = word_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (rx_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            tick_d  = '0;
            busy_d  = 1'b1;
          end else if (idx_q != '0) begin
            // Inter-character timeout: drop the partial word silently.
            if (to_q == TO_LAST) begin
              idx_d  = '0;
              to_d   = '0;
              word_d = '0;
              busy_d = 1'b0;
            end else begin
              to_d = to_q + 1'b1;
            end
          end
        end

        ST_START: begin
          if (tick_q == MID_TICK) begin
            tick_d = '0;
            if (rxd_s) begin
              // Glitch: keep any partial word, stay busy only if one exists.
              state_d = ST_IDLE;
              busy_d  = (idx_q != '0);
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[7:1]};
            if (bit_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (rxd_s) begin
              word_d[int'(idx_q) * UART_DATA_BITS +: UART_DATA_BITS] = shift_q;
              state_d = ST_IDLE;
              to_d    = '0;
              if (idx_q == LAST_IDX) begin
                data_d  = word_d;
                word_d  = '0;
                valid_d = 1'b1;
                idx_d   = '0;
                busy_d  = 1'b0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              word_d  = '0;
              idx_d   = '0;
              to_d    = '0;
              busy_d  = 1'b0;
              state_d = ST_WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit.
          if (rxd_s) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      shift_q <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_bit_counter.sv
module tb_uart_rx_bit_counter;

  localparam int unsigned NBYTES       = 2;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int unsigned WORD_W       = 8 * NBYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_en;
  logic              RxD;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_busy;
  logic              frame_err;

  int compared   = 0;
  int mismatched = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] model_last;
  int valid_seen    = 0;
  int ferr_seen     = 0;
  int words_sent    = 0;
  int ferr_expected = 0;
  int unsigned tick_count = 0;

  uart_rx_bit_counter #(
    .NBYTES      (NBYTES),
    .OVERSAMPLE  (OVERSAMPLE),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .RxD      (RxD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // rx_en: one clock high out of every three.
  initial begin
    rx_en = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      rx_en = 1'b1;
      @(negedge clk);
      rx_en = 1'b0;
    end
  end

  always @(posedge clk) if (rx_en) tick_count <= tick_count + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    int unsigned target;
    target = tick_count + n;
    while (tick_count < target) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] b, input bit good_stop);
    RxD = 1'b0;
    wait_ticks(OVERSAMPLE);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_ticks(OVERSAMPLE);
    end
    RxD = good_stop;
    wait_ticks(OVERSAMPLE);
    RxD = 1'b1;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int unsigned gap_ticks);
    exp_q.push_back(w);
    words_sent++;
    for (int k = 0; k < NBYTES; k++) begin
      send_char(w[8*k +: 8], 1'b1);
      if (k != NBYTES - 1) wait_ticks(gap_ticks);
    end
    model_last = w;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_seen++;
      check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("rx_data", 64'(rx_data), 64'(exp_q.pop_front()));
    end
    if (frame_err) ferr_seen++;
    if (rx_valid || frame_err) check("valid_ferr_exclusive", 64'(rx_valid && frame_err), 64'd0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c2;
    rst = 1'b1;
    RxD = 1'b1;
    model_last = '0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 64'(rx_data), 64'd0);
    check("reset_rx_valid", 64'(rx_valid), 64'd0);
    check("reset_rx_busy", 64'(rx_busy), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    wait_ticks(2 * OVERSAMPLE);

    // Single word.
    send_word(16'hBC0A, 0);
    check("busy_after_word", 64'(rx_busy), 64'd0);
    check("valid_count_1", 64'(valid_seen), 64'd1);
    check("no_ferr_1", 64'(ferr_seen), 64'd0);

    // Back-to-back words.
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h00FF, 0);
    check("valid_count_4", 64'(valid_seen), 64'd4);

    // Short low glitch while idle.
    RxD = 1'b0;
    wait_ticks(3);
    RxD = 1'b1;
    wait_ticks(2 * OVERSAMPLE);
    check("glitch_rx_data", 64'(rx_data), 64'(model_last));
    check("glitch_valid_count", 64'(valid_seen), 64'd4);
    check("glitch_no_ferr", 64'(ferr_seen), 64'd0);
    check("glitch_busy", 64'(rx_busy), 64'd0);

    // Bad stop bit.
    send_char(8'h55, 1'b0);
    ferr_expected++;
    wait_ticks(OVERSAMPLE);
    check("ferr_count_1", 64'(ferr_seen), 64'd1);
    check("ferr_no_valid", 64'(valid_seen), 64'd4);
    check("ferr_busy", 64'(rx_busy), 64'd0);
    send_word(16'h0F0F, 0);
    check("valid_after_ferr", 64'(valid_seen), 64'd5);

    // Partial word then inter-character timeout.
    send_char(8'hAA, 1'b1);
    check("partial_busy", 64'(rx_busy), 64'd1);
    wait_ticks(19 * OVERSAMPLE);
    check("busy_before_timeout", 64'(rx_busy), 64'd1);
    wait_ticks(2 * OVERSAMPLE);
    check("busy_after_timeout", 64'(rx_busy), 64'd0);
    wait_ticks(4 * OVERSAMPLE);
    check("timeout_no_valid", 64'(valid_seen), 64'd5);
    check("timeout_rx_data", 64'(rx_data), 64'(model_last));
    send_word(16'h3C5A, 0);
    check("valid_after_timeout", 64'(valid_seen), 64'd6);

    // Reset during bit 4 of the second character.
    send_char(8'hA5, 1'b1);
    c2 = 8'hC3;
    RxD = 1'b0;
    wait_ticks(OVERSAMPLE);
    for (int i = 0; i < 4; i++) begin
      RxD = c2[i];
      wait_ticks(OVERSAMPLE);
    end
    RxD = c2[4];
    wait_ticks(OVERSAMPLE / 2);
    rst = 1'b1;
    RxD = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", 64'(rx_data), 64'd0);
    check("midrst_rx_valid", 64'(rx_valid), 64'd0);
    check("midrst_rx_busy", 64'(rx_busy), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    model_last = '0;
    wait_ticks(12 * OVERSAMPLE);
    check("midrst_idle_busy", 64'(rx_busy), 64'd0);
    send_word(16'h7E81, 0);
    check("valid_after_rst", 64'(valid_seen), 64'd7);

    // Randomised words with random inter-character and inter-word gaps.
    for (int n = 0; n < 12; n++) begin
      send_word(WORD_W'($urandom), $urandom_range(0, 5 * OVERSAMPLE));
      wait_ticks($urandom_range(0, 3 * OVERSAMPLE));
    end
    wait_ticks(2 * OVERSAMPLE);

    check("final_valid_count", 64'(valid_seen), 64'(words_sent));
    check("final_ferr_count", 64'(ferr_seen), 64'(ferr_expected));
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_rx_data", 64'(rx_data), 64'(model_last));
    check("final_busy", 64'(rx_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
